// File: rtl/decode_queue.sv
// RV32I decode stage feeding a DEPTH-entry FIFO of decoded instructions; 1-cycle push-to-head latency.
// Backpressure: if_ready drops when full, flushing, in reset or paused; the head is held until out_ready.
package decode_queue_pkg;
  typedef enum logic [2:0] {TYPE_R, TYPE_I, TYPE_S, TYPE_B, TYPE_U, TYPE_J} inst_ty_t;
  typedef enum logic [5:0] {
    OPT_LUI, OPT_AUIPC, OPT_JAL, OPT_JALR,
    OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU,
    OPT_LB, OPT_LH, OPT_LW, OPT_LBU, OPT_LHU, OPT_SB, OPT_SH, OPT_SW,
    OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI, OPT_ANDI, OPT_SLLI, OPT_SRLI, OPT_SRAI,
    OPT_ADD, OPT_SUB, OPT_SLL, OPT_SLT, OPT_SLTU, OPT_XOR, OPT_SRL, OPT_SRA, OPT_OR, OPT_AND
  } inst_opt_t;
  typedef logic [4:0] reg_idx_t;
  typedef struct packed {
    logic [31:0] pc;
    inst_ty_t    ty;
    inst_opt_t   opt;
    reg_idx_t    rd;
    reg_idx_t    rs1;
    reg_idx_t    rs2;
    logic [31:0] imm;
    logic        is_ls;
    logic        use_rs1;
    logic        use_rs2;
    logic        illegal;
  } entry_t;
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output inst_ty_t    out_ty,
  output inst_opt_t   out_opt,
  output reg_idx_t    out_rd,
  output reg_idx_t    out_rs1,
  output reg_idx_t    out_rs2,
  output logic [31:0] out_imm,
  output logic        out_is_ls,
  output logic        out_use_rs1,
  output logic        out_use_rs2,
  output logic        out_illegal
);
  logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  entry_t            dec, head_ent;
  logic              push, pop, ill;

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = if_inst[6:0];
  assign f3     = if_inst[14:12];
  assign f7     = if_inst[31:25];
  assign imm_i  = {{20{if_inst[31]}}, if_inst[31:20]};
  assign imm_s  = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
  assign imm_b  = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
  assign imm_u  = {if_inst[31:12], 12'b0};
  assign imm_j  = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};

  always_comb begin
    dec     = '0;
    ill     = 1'b0;
    dec.pc  = if_pc;
    dec.ty  = TYPE_I;
    dec.opt = OPT_ADDI;
    dec.rd  = if_inst[11:7];
    case (opcode)
      7'h37: begin dec.ty = TYPE_U; dec.opt = OPT_LUI;   dec.imm = imm_u; end
      7'h17: begin dec.ty = TYPE_U; dec.opt = OPT_AUIPC; dec.imm = imm_u; end
      7'h6F: begin dec.ty = TYPE_J; dec.opt = OPT_JAL;   dec.imm = imm_j; end
      7'h67: begin
        dec.opt = OPT_JALR; dec.imm = imm_i; dec.use_rs1 = 1'b1;
        ill = (f3 != 3'd0);
      end
      7'h63: begin
        dec.ty = TYPE_B; dec.imm = imm_b; dec.rd = '0;
        dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1;
        case (f3)
          3'd0: dec.opt = OPT_BEQ;
          3'd1: dec.opt = OPT_BNE;
          3'd4: dec.opt = OPT_BLT;
          3'd5: dec.opt = OPT_BGE;
          3'd6: dec.opt = OPT_BLTU;
          3'd7: dec.opt = OPT_BGEU;
          default: ill = 1'b1;
        endcase
      end
      7'h03: begin
        dec.imm = imm_i; dec.is_ls = 1'b1; dec.use_rs1 = 1'b1;
        case (f3)
          3'd0: dec.opt = OPT_LB;
          3'd1: dec.opt = OPT_LH;
          3'd2: dec.opt = OPT_LW;
          3'd4: dec.opt = OPT_LBU;
          3'd5: dec.opt = OPT_LHU;
          default: ill = 1'b1;
        endcase
      end
      7'h23: begin
        dec.ty = TYPE_S; dec.imm = imm_s; dec.rd = '0; dec.is_ls = 1'b1;
        dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1;
        case (f3)
          3'd0: dec.opt = OPT_SB;
          3'd1: dec.opt = OPT_SH;
          3'd2: dec.opt = OPT_SW;
          default: ill = 1'b1;
        endcase
      end
      7'h13: begin
        dec.imm = imm_i; dec.use_rs1 = 1'b1;
        case (f3)
          3'd0: dec.opt = OPT_ADDI;
          3'd2: dec.opt = OPT_SLTI;
          3'd3: dec.opt = OPT_SLTIU;
          3'd4: dec.opt = OPT_XORI;
          3'd6: dec.opt = OPT_ORI;
          3'd7: dec.opt = OPT_ANDI;
          3'd1: begin
            dec.opt = OPT_SLLI; dec.imm = {27'b0, if_inst[24:20]};
            ill = (f7 != 7'h00);
          end
          default: begin
            dec.opt = if_inst[30] ? OPT_SRAI : OPT_SRLI;
            dec.imm = {27'b0, if_inst[24:20]};
            ill = (f7 != 7'h00) && (f7 != 7'h20);
          end
        endcase
      end
      7'h33: begin
        dec.ty = TYPE_R; dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1;
        ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
        case (f3)
          3'd0: dec.opt = if_inst[30] ? OPT_SUB : OPT_ADD;
          3'd1: dec.opt = OPT_SLL;
          3'd2: dec.opt = OPT_SLT;
          3'd3: dec.opt = OPT_SLTU;
          3'd4: dec.opt = OPT_XOR;
          3'd5: dec.opt = if_inst[30] ? OPT_SRA : OPT_SRL;
          3'd6: dec.opt = OPT_OR;
          default: dec.opt = OPT_AND;
        endcase
      end
      default: ill = 1'b1;
    endcase
    dec.rs1 = dec.use_rs1 ? if_inst[19:15] : '0;
    dec.rs2 = dec.use_rs2 ? if_inst[24:20] : '0;
    // Malformed encodings still occupy a slot, as an ADDI x0,x0,0 tagged illegal.
    if (ill) begin
      dec         = '0;
      dec.pc      = if_pc;
      dec.ty      = TYPE_I;
      dec.opt     = OPT_ADDI;
      dec.illegal = 1'b1;
    end
  end

  assign if_ready  = rdy_in & ~rst_in & ~flush_in & (count_q != (ADDR_W+1)'(DEPTH));
  assign out_valid = rdy_in & (count_q != '0);
  assign push      = if_valid & if_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (rst_in || (rdy_in && flush_in)) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = dec;
        tail_d        = tail_q + ADDR_W'(1);
      end
      if (pop) head_d = head_q + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
    mem_q <= mem_d;
  end

  assign head_ent    = out_valid ? mem_q[head_q] : '0;
  assign out_pc      = head_ent.pc;
  assign out_ty      = head_ent.ty;
  assign out_opt     = head_ent.opt;
  assign out_rd      = head_ent.rd;
  assign out_rs1     = head_ent.rs1;
  assign out_rs2     = head_ent.rs2;
  assign out_imm     = head_ent.imm;
  assign out_is_ls   = head_ent.is_ls;
  assign out_use_rs1 = head_ent.use_rs1;
  assign out_use_rs2 = head_ent.use_rs2;
  assign out_illegal = head_ent.illegal;
endmodule
